// File: rtl/distributive_verification.sv
// Cross-checks the distributive law a*(b+c) == a*b + a*c using two independent
// structural datapaths, registering both results and their equality flag.

module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b0;

    // Full-adder chain; the carry out of the top bit is never needed because
    // callers size WIDTH so that the true sum always fits.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end
endmodule

module shift_add_multiplier #(
    parameter int AW = 4,
    parameter int BW = 4
) (
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    output logic [AW+BW-1:0] product
);
    localparam int PW = AW + BW;

    logic [PW-1:0] partial [BW];
    logic [PW-1:0] acc     [BW];

    // AND-array partial products, each shifted to its bit weight.
    for (genvar i = 0; i < BW; i++) begin : g_pp
        assign partial[i] = {{BW{1'b0}}, (a & {AW{b[i]}})} << i;
    end

    assign acc[0] = partial[0];

    for (genvar i = 1; i < BW; i++) begin : g_acc
        ripple_adder #(.WIDTH(PW)) u_add (
            .a   (acc[i-1]),
            .b   (partial[i]),
            .sum (acc[i])
        );
    end

    assign product = acc[BW-1];
endmodule

module distributive_verification (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    output logic [8:0] op1,
    output logic [8:0] op2,
    output logic       Z
);
    logic [4:0] sum_bc;
    logic [8:0] factored;
    logic [7:0] prod_ab;
    logic [7:0] prod_ac;
    logic [8:0] expanded;
    logic       equal;

    // Factored form: a * (b + c)
    ripple_adder #(.WIDTH(5)) u_sum_bc (
        .a   ({1'b0, in2}),
        .b   ({1'b0, in3}),
        .sum (sum_bc)
    );

    shift_add_multiplier #(.AW(4), .BW(5)) u_mul_factored (
        .a       (in1),
        .b       (sum_bc),
        .product (factored)
    );

    // Expanded form: a*b + a*c, on its own multipliers and adder
    shift_add_multiplier #(.AW(4), .BW(4)) u_mul_ab (
        .a       (in1),
        .b       (in2),
        .product (prod_ab)
    );

    shift_add_multiplier #(.AW(4), .BW(4)) u_mul_ac (
        .a       (in1),
        .b       (in3),
        .product (prod_ac)
    );

    ripple_adder #(.WIDTH(9)) u_sum_expanded (
        .a   ({1'b0, prod_ab}),
        .b   ({1'b0, prod_ac}),
        .sum (expanded)
    );

    assign equal = (factored == expanded);

    always_ff @(posedge clk) begin
        if (rst) begin
            op1 <= 9'h000;
            op2 <= 9'h000;
            Z   <= 1'b0;
        end else begin
            op1 <= factored;
            op2 <= expanded;
            Z   <= equal;
        end
    end
endmodule

// File: tb/tb_distributive_verification.sv
// Self-checking bench for distributive_verification: directed vectors, hold,
// mid-stream reset, exhaustive sweep and random stimulus against an integer model.

module tb_distributive_verification;
    logic       clk;
    logic       rst;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] in3;
    logic [8:0] op1;
    logic [8:0] op2;
    logic       Z;

    int checks;
    int failures;

    distributive_verification dut (
        .clk (clk),
        .rst (rst),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .op1 (op1),
        .op2 (op2),
        .Z   (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model_factored(int a, int b, int c);
        int r;
        r = a * (b + c);
        return r[8:0];
    endfunction

    function automatic logic [8:0] model_expanded(int a, int b, int c);
        int r;
        r = a * b + a * c;
        return r[8:0];
    endfunction

    // Drive inputs, then let one rising edge capture them and sample just after.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic r);
        in1 = a;
        in2 = b;
        in3 = c;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(4'd3, 4'd3, 4'd1, 1'b1);
        step(4'd3, 4'd3, 4'd1, 1'b1);
        checks++; if (op1 !== 9'h000) begin failures++; $display("[TB] FAIL reset_op1 got %h expected %h", op1, 9'h000); end
        checks++; if (op2 !== 9'h000) begin failures++; $display("[TB] FAIL reset_op2 got %h expected %h", op2, 9'h000); end
        checks++; if (Z !== 1'b0) begin failures++; $display("[TB] FAIL reset_z got %b expected 0", Z); end
        step(4'd3, 4'd3, 4'd1, 1'b0);
        checks++; if (op1 !== 9'h00C) begin failures++; $display("[TB] FAIL release_op1 got %h expected %h", op1, 9'h00C); end
        checks++; if (op2 !== 9'h00C) begin failures++; $display("[TB] FAIL release_op2 got %h expected %h", op2, 9'h00C); end
        checks++; if (Z !== 1'b1) begin failures++; $display("[TB] FAIL release_z got %b expected 1", Z); end
    endtask

    task automatic test_vectors();
        logic [3:0]  va [5] = '{4'hA, 4'hF, 4'h2, 4'h0, 4'hF};
        logic [3:0]  vb [5] = '{4'hF, 4'h2, 4'h8, 4'h0, 4'hF};
        logic [3:0]  vc [5] = '{4'h9, 4'h2, 4'hB, 4'h0, 4'hF};
        logic [8:0]  ve [5] = '{9'h0F0, 9'h03C, 9'h026, 9'h000, 9'h1C2};
        for (int i = 0; i < 5; i++) begin
            step(va[i], vb[i], vc[i], 1'b0);
            checks++; if (op1 !== ve[i]) begin failures++; $display("[TB] FAIL vector%0d_op1 got %h expected %h", i, op1, ve[i]); end
            checks++; if (op2 !== ve[i]) begin failures++; $display("[TB] FAIL vector%0d_op2 got %h expected %h", i, op2, ve[i]); end
            checks++; if (Z !== 1'b1) begin failures++; $display("[TB] FAIL vector%0d_z got %b expected 1", i, Z); end
        end
    endtask

    task automatic test_hold();
        logic [8:0] held;
        step(4'h7, 4'h5, 4'h3, 1'b0);
        held = model_factored(7, 5, 3);
        in1 = 4'hE;
        in2 = 4'hD;
        in3 = 4'h1;
        #3;
        checks++; if (op1 !== held) begin failures++; $display("[TB] FAIL hold_op1 got %h expected %h", op1, held); end
        checks++; if (op2 !== held) begin failures++; $display("[TB] FAIL hold_op2 got %h expected %h", op2, held); end
        @(posedge clk);
        #1;
        checks++; if (op1 !== model_factored(14, 13, 1)) begin failures++; $display("[TB] FAIL hold_next_op1 got %h expected %h", op1, model_factored(14, 13, 1)); end
        checks++; if (op2 !== model_expanded(14, 13, 1)) begin failures++; $display("[TB] FAIL hold_next_op2 got %h expected %h", op2, model_expanded(14, 13, 1)); end
    endtask

    task automatic test_midstream_reset();
        step(4'h9, 4'h4, 4'h6, 1'b0);
        checks++; if (op1 !== model_factored(9, 4, 6)) begin failures++; $display("[TB] FAIL mid_pre_op1 got %h expected %h", op1, model_factored(9, 4, 6)); end
        step(4'hC, 4'hB, 4'h5, 1'b1);
        checks++; if (op1 !== 9'h000) begin failures++; $display("[TB] FAIL mid_rst_op1 got %h expected %h", op1, 9'h000); end
        checks++; if (op2 !== 9'h000) begin failures++; $display("[TB] FAIL mid_rst_op2 got %h expected %h", op2, 9'h000); end
        checks++; if (Z !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_z got %b expected 0", Z); end
        step(4'h5, 4'h3, 4'hE, 1'b0);
        checks++; if (op1 !== model_factored(5, 3, 14)) begin failures++; $display("[TB] FAIL mid_resume_op1 got %h expected %h", op1, model_factored(5, 3, 14)); end
        checks++; if (op2 !== model_expanded(5, 3, 14)) begin failures++; $display("[TB] FAIL mid_resume_op2 got %h expected %h", op2, model_expanded(5, 3, 14)); end
        checks++; if (Z !== 1'b1) begin failures++; $display("[TB] FAIL mid_resume_z got %b expected 1", Z); end
    endtask

    task automatic test_sweep();
        logic [8:0] e1;
        logic [8:0] e2;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 16; c++) begin
                    step(4'(a), 4'(b), 4'(c), 1'b0);
                    e1 = model_factored(a, b, c);
                    e2 = model_expanded(a, b, c);
                    checks++; if (op1 !== e1) begin failures++; $display("[TB] FAIL sweep_op1 (%0d,%0d,%0d) got %h expected %h", a, b, c, op1, e1); end
                    checks++; if (op2 !== e2) begin failures++; $display("[TB] FAIL sweep_op2 (%0d,%0d,%0d) got %h expected %h", a, b, c, op2, e2); end
                    checks++; if (Z !== (e1 == e2)) begin failures++; $display("[TB] FAIL sweep_z (%0d,%0d,%0d) got %b expected 1", a, b, c, Z); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       r;
        for (int i = 0; i < 300; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 19) == 0);
            step(a, b, c, r);
            checks++; if (op1 !== (r ? 9'h000 : model_factored(a, b, c))) begin failures++; $display("[TB] FAIL random_op1 got %h rst=%b in=(%h,%h,%h)", op1, r, a, b, c); end
            checks++; if (op2 !== (r ? 9'h000 : model_expanded(a, b, c))) begin failures++; $display("[TB] FAIL random_op2 got %h rst=%b in=(%h,%h,%h)", op2, r, a, b, c); end
            checks++; if (Z !== !r) begin failures++; $display("[TB] FAIL random_z got %b expected %b", Z, !r); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        in1 = 4'h0;
        in2 = 4'h0;
        in3 = 4'h0;
        #2;
        test_reset();
        test_vectors();
        test_hold();
        test_midstream_reset();
        test_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
